// File: rtl/ocm_pkg.sv
// ocm_pkg: shared defaults and arbiter state encoding for the OCM channel arbiter.
package ocm_pkg;
    localparam int OCM_ADDR_W    = 14;
    localparam int OCM_DATA_W    = 64;
    localparam int OCM_DEPTH     = 8960;
    localparam int OCM_MAX_BEATS = 16;

    // Encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;
endpackage

// File: rtl/ocm_rsp_tracker.sv
// ocm_rsp_tracker: one-deep read/error response pipeline that steers each
// response back to the requester that issued the beat.
module ocm_rsp_tracker #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_acc,
    input  logic              i_rd,
    input  logic              i_oor,
    input  logic              i_owner,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_rvalid,
    output logic [1:0]        o_err,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1
);
    logic r_valid, r_err, r_owner;
    logic w_rv, w_er;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_valid <= i_acc && i_rd;
            r_err   <= i_acc && i_oor;
            r_owner <= i_owner;
        end
    end

    assign w_rv     = reset_n && r_valid;
    assign w_er     = reset_n && r_err;
    assign o_rvalid = {w_rv && r_owner, w_rv && !r_owner};
    assign o_err    = {w_er && r_owner, w_er && !r_owner};
    // Out-of-range reads return zero instead of whatever the memory drives.
    assign o_rdata0 = (o_rvalid[0] && !r_err) ? i_mem_rdata : '0;
    assign o_rdata1 = (o_rvalid[1] && !r_err) ? i_mem_rdata : '0;
endmodule

// File: rtl/ocm_channel_arbiter.sv
// ocm_channel_arbiter: two-requester round-robin arbiter with a beat-count
// fairness limit, multiplexed onto a single on-chip memory port.
module ocm_channel_arbiter
    import ocm_pkg::*;
#(
    parameter int ADDR_W    = OCM_ADDR_W,
    parameter int DATA_W    = OCM_DATA_W,
    parameter int DEPTH     = OCM_DEPTH,
    parameter int MAX_BEATS = OCM_MAX_BEATS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rq0_valid,
    output logic                rq0_ready,
    input  logic                rq0_write,
    input  logic [ADDR_W-1:0]   rq0_addr,
    input  logic [DATA_W-1:0]   rq0_wdata,
    input  logic [DATA_W/8-1:0] rq0_byteen,
    output logic                rq0_rvalid,
    output logic [DATA_W-1:0]   rq0_rdata,
    output logic                rq0_err,
    input  logic                rq1_valid,
    output logic                rq1_ready,
    input  logic                rq1_write,
    input  logic [ADDR_W-1:0]   rq1_addr,
    input  logic [DATA_W-1:0]   rq1_wdata,
    input  logic [DATA_W/8-1:0] rq1_byteen,
    output logic                rq1_rvalid,
    output logic [DATA_W-1:0]   rq1_rdata,
    output logic                rq1_err,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [1:0]          grant
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(MAX_BEATS + 1);

    state_t            r_state, w_next;
    logic              r_ptr, w_ptr_next;
    logic [CW-1:0]     r_cnt, w_cnt_inc, w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic              w_busy, w_own, w_sv, w_ov, w_acc, w_write, w_oor, w_release;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic [1:0]        w_rvalid, w_err;

    assign w_busy  = (r_state == GNT0) || (r_state == GNT1);
    assign w_own   = (r_state == GNT1);
    assign w_sv    = w_own ? rq1_valid : rq0_valid;
    assign w_ov    = w_own ? rq0_valid : rq1_valid;
    assign w_acc   = reset_n && w_busy && w_sv;
    assign w_write = w_own ? rq1_write : rq0_write;
    assign w_addr  = w_own ? rq1_addr : rq0_addr;
    assign w_wdata = w_own ? rq1_wdata : rq0_wdata;
    assign w_be    = w_own ? rq1_byteen : rq0_byteen;
    assign w_oor   = 32'(w_addr) >= DEPTH;

    // Count includes the beat taken this cycle so the hand-over lands right after the last allowed beat.
    assign w_cnt_inc = (w_acc && r_cnt != CW'(MAX_BEATS)) ? r_cnt + CW'(1) : r_cnt;
    assign w_release = !w_sv || (w_cnt_inc == CW'(MAX_BEATS) && w_ov);

    always_comb begin
        w_next     = r_state;
        w_ptr_next = r_ptr;
        w_cnt_next = w_cnt_inc;
        if (!w_busy) begin
            w_cnt_next = '0;
            w_next     = (rq0_valid && rq1_valid) ? (r_ptr ? GNT1 : GNT0) :
                         rq0_valid ? GNT0 : rq1_valid ? GNT1 : IDLE;
        end else if (w_release) begin
            w_next     = w_ov ? (w_own ? GNT0 : GNT1) : IDLE;
            w_ptr_next = !w_own;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= mem_address;
        end
    end

    assign rq0_ready      = w_acc && !w_own;
    assign rq1_ready      = w_acc && w_own;
    assign mem_chipselect = w_acc && !w_oor;
    assign mem_write      = mem_chipselect && w_write;
    assign mem_address    = !reset_n ? '0 : (w_acc ? w_addr : r_addr);
    assign mem_writedata  = w_acc ? w_wdata : '0;
    assign mem_byteenable = w_acc ? w_be : '0;
    assign mem_clken      = reset_n;
    assign grant          = reset_n ? 2'(r_state) : 2'b00;

    ocm_rsp_tracker #(.DATA_W(DATA_W)) u_rsp (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_acc       (w_acc),
        .i_rd        (!w_write),
        .i_oor       (w_oor),
        .i_owner     (w_own),
        .i_mem_rdata (mem_readdata),
        .o_rvalid    (w_rvalid),
        .o_err       (w_err),
        .o_rdata0    (rq0_rdata),
        .o_rdata1    (rq1_rdata)
    );

    assign rq0_rvalid = w_rvalid[0];
    assign rq1_rvalid = w_rvalid[1];
    assign rq0_err    = w_err[0];
    assign rq1_err    = w_err[1];
endmodule
